// File: rtl/seq_divider_16by8_if.sv
// rtl/seq_divider_16by8_if.sv - request/result bundle for the sequential 16-by-8 divider
interface seq_divider_16by8_if #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
);
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             done;
  logic             busy;
  logic             dz;

  // Requester side: drives operands, observes results
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, dz
  );

  // Divider side: consumes operands, produces results
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, dz
  );
endinterface

// File: rtl/seq_divider_16by8.sv
// rtl/seq_divider_16by8.sv - restoring divider, one quotient bit per clock
module seq_divider_16by8 #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input logic                clk,
  input logic                rst,
  seq_divider_16by8_if.slave bus
);
  localparam int CNT_W = $clog2(DVD_W) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state;
  logic [DVS_W:0]   rem_w;   // partial remainder, one guard bit wider than the divisor
  logic [DVD_W-1:0] quo_w;   // dividend shifts out the top while quotient bits enter the bottom
  logic [DVS_W-1:0] dvs_r;
  logic [CNT_W-1:0] cnt;

  logic [DVD_W-1:0] quotient_r;
  logic [DVS_W-1:0] remainder_r;
  logic             done_r;
  logic             busy_r;
  logic             dz_r;

  logic [DVS_W+1:0] shifted;
  logic [DVS_W+1:0] diff;
  logic             neg;
  logic [DVS_W:0]   new_rem;
  logic [DVD_W-1:0] new_quo;

  // One restoring step: shift in the next dividend bit, trial subtract, keep or restore
  always_comb begin
    shifted = {rem_w, quo_w[DVD_W-1]};
    diff    = shifted - {2'b00, dvs_r};
    neg     = diff[DVS_W+1];
    new_rem = neg ? shifted[DVS_W:0] : diff[DVS_W:0];
    new_quo = {quo_w[DVD_W-2:0], ~neg};
  end

  // Control FSM and all registered state/outputs; reset wins over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_w       <= '0;
      quo_w       <= '0;
      dvs_r       <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      dz_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              quo_w  <= bus.dividend;
              rem_w  <= '0;
              dvs_r  <= bus.divisor;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= CALC;
            end else begin
              // Divide by zero resolves immediately without entering CALC
              quotient_r  <= '1;
              remainder_r <= bus.dividend[DVS_W-1:0];
              dz_r        <= 1'b1;
              done_r      <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_w <= new_rem;
          quo_w <= new_quo;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(DVD_W - 1)) begin
            // Final remainder is below the divisor, so the guard bit is always zero
            quotient_r  <= new_quo;
            remainder_r <= new_rem[DVS_W-1:0];
            dz_r        <= 1'b0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb/tb_seq_divider_16by8.sv - randomized and directed checks against an arithmetic model
module tb_seq_divider_16by8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  seq_divider_16by8_if #(.DVD_W(16), .DVS_W(8)) bus ();

  seq_divider_16by8 #(.DVD_W(16), .DVS_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Behavioural model: arithmetic results scheduled on the edge they must appear
  int          edge_n = 0;
  int          free_edge = 0;
  bit          pending = 0;
  int          pend_edge;
  logic [15:0] pend_q;
  logic [7:0]  pend_r;
  logic [15:0] exp_q = '0;
  logic [7:0]  exp_r = '0;
  logic        exp_dz = 0, exp_done = 0, exp_busy = 0;
  bit          model_valid = 0;

  always @(posedge clk) begin
    edge_n++;
    exp_done = 0;
    if (rst) begin
      pending = 0;
      exp_q = '0; exp_r = '0; exp_dz = 0; exp_busy = 0;
      free_edge = edge_n + 1;
      model_valid = 1;
    end else begin
      if (pending && edge_n == pend_edge) begin
        exp_q = pend_q; exp_r = pend_r; exp_dz = 0;
        exp_done = 1; exp_busy = 0; pending = 0;
      end
      if (!pending && edge_n >= free_edge && bus.start) begin
        if (bus.divisor == 8'd0) begin
          exp_q = 16'hFFFF; exp_r = bus.dividend[7:0]; exp_dz = 1;
          exp_done = 1; free_edge = edge_n + 1;
        end else begin
          pend_q    = bus.dividend / {8'd0, bus.divisor};
          pend_r    = 8'(bus.dividend % {8'd0, bus.divisor});
          pend_edge = edge_n + 16;
          pending   = 1;
          exp_busy  = 1;
          free_edge = edge_n + 17;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("quotient", 32'(bus.quotient), 32'(exp_q));
      chk("remainder", 32'(bus.remainder), 32'(exp_r));
      chk("dz", 32'(bus.dz), 32'(exp_dz));
    end
  end

  task automatic wait_done(input int limit, output int lat, output bit busy_seen);
    lat = 0;
    busy_seen = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_seen = 1;
    end while (!bus.done && lat < limit);
    if (!bus.done) chk("done_timeout", 32'(lat), 32'(limit + 1));
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r, input logic dzx,
                        input int lat_exp);
    int lat;
    bit bs;
    bus.start = 1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 0; bus.dividend = $urandom; bus.divisor = $urandom;
    lat = 1;
    if (!bus.done) begin
      wait_done(40, lat, bs);
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({name, "_q"}, 32'(bus.quotient), 32'(q));
    chk({name, "_r"}, 32'(bus.remainder), 32'(r));
    chk({name, "_dz"}, 32'(bus.dz), 32'(dzx));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit bs;
    int a, b;
    bus.start = 0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_all_zero", {bus.quotient, bus.remainder, 5'd0, bus.done, bus.busy, bus.dz}, 32'd0);

    run_op("mul_inverse", 16'h7530, 8'h96, 16'h00C8, 8'h00, 1'b0, 17);
    run_op("general",     16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17);
    run_op("max",         16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17);
    run_op("small",       16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 17);
    run_op("zero_dvd",    16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 17);
    run_op("max_dvs1",    16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17);

    // Divide by zero: one-edge latency, busy never rises
    bus.start = 1; bus.dividend = 16'h1234; bus.divisor = 8'h00;
    @(negedge clk);
    bus.start = 0;
    chk("dz_done", 32'(bus.done), 32'd1);
    chk("dz_busy", 32'(bus.busy), 32'd0);
    chk("dz_q", 32'(bus.quotient), 32'hFFFF);
    chk("dz_r", 32'(bus.remainder), 32'h34);
    chk("dz_flag", 32'(bus.dz), 32'd1);
    repeat (3) @(negedge clk);

    // A second start mid-calculation is ignored
    bus.start = 1; bus.dividend = 16'h03E8; bus.divisor = 8'h07;
    @(negedge clk);
    bus.start = 0;
    repeat (5) @(negedge clk);
    bus.start = 1; bus.dividend = 16'h1111; bus.divisor = 8'h03;
    @(negedge clk);
    bus.start = 0;
    wait_done(40, lat, bs);
    chk("ignore_q", 32'(bus.quotient), 32'h008E);
    chk("ignore_r", 32'(bus.remainder), 32'h06);
    repeat (20) @(negedge clk);
    chk("ignore_no_second", 32'(bus.busy), 32'd0);

    // Reset on the 8th CALC edge abandons the operation
    bus.start = 1; bus.dividend = 16'h7530; bus.divisor = 8'h96;
    @(negedge clk);
    bus.start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_outputs", {bus.quotient, bus.remainder, 5'd0, bus.done, bus.busy, bus.dz}, 32'd0);
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) lat++;
    end
    chk("rst_mid_no_done", 32'(lat), 32'd0);
    run_op("after_rst", 16'h7530, 8'h96, 16'h00C8, 8'h00, 1'b0, 17);

    // Multiplier-inverse sweep with start held high (sampled, plus corners)
    bus.start = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) begin a = 1; b = 1; end
      else if (i == 1) begin a = 255; b = 255; end
      else if (i == 2) begin a = 1; b = 255; end
      else begin a = $urandom_range(1, 255); b = $urandom_range(1, 255); end
      bus.dividend = 16'(a * b);
      bus.divisor  = 8'(b);
      wait_done(40, lat, bs);
      if (i > 0) chk("sweep_period", 32'(lat), 32'd17);
      chk("sweep_q", 32'(bus.quotient), 32'(a));
      chk("sweep_r", 32'(bus.remainder), 32'd0);
    end
    bus.start = 0;
    repeat (20) @(negedge clk);

    // Free-running random traffic, checked by the model alone
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.dividend = $urandom;
      bus.divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rst          = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    bus.start = 0; rst = 0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
